// File: rtl/instr_fetch.sv
// Instruction fetch: PC, req/ack memory port, one-entry skid buffer and NOP fill.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect halt and o_fetch_misaligned.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        o_fetch_misaligned
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        r_active;
  logic [31:0] r_pc;
  logic [31:0] r_pc_pend;
  logic        r_drop;
  logic [31:0] r_out_data;
  logic [31:0] r_out_pc;
  logic        r_out_valid;
  logic [31:0] r_skid_data;
  logic [31:0] r_skid_pc;
  logic        r_skid_valid;

  logic        w_halt;
  logic        w_ack;
  logic        w_keep;
  logic [31:0] w_redir_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misaligned;
  logic w_misalign;
  assign w_misalign         = i_redirect & (|i_redirect_pc[1:0]);
  assign w_halt             = r_misaligned;
  assign w_redir_pc         = i_redirect_pc;
  assign o_fetch_misaligned = r_misaligned;
`else
  assign w_halt     = 1'b0;
  assign w_redir_pc = i_redirect_pc & ~32'h3;
`endif

  // r_pc only moves on ack or an idle-port redirect, so the address is stable
  // for the whole life of a request; a redirect during one is parked in r_pc_pend.
  assign o_mem_req     = r_active & ~r_skid_valid & ~w_halt;
  assign o_mem_addr    = r_pc;
  assign w_ack         = o_mem_req & i_mem_ack;
  assign w_keep        = w_ack & ~r_drop;
  assign o_instr       = r_out_valid ? r_out_data : NOP;
  assign o_instr_pc    = r_out_pc;
  assign o_instr_valid = r_out_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active     <= 1'b0;
      r_pc         <= RESET_PC;
      r_pc_pend    <= RESET_PC;
      r_drop       <= 1'b0;
      r_out_data   <= NOP;
      r_out_pc     <= RESET_PC;
      r_out_valid  <= 1'b0;
      r_skid_data  <= NOP;
      r_skid_pc    <= RESET_PC;
      r_skid_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      r_active <= 1'b1;
      if (i_redirect) begin
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
        if (w_ack) begin
          r_pc   <= w_redir_pc;
          r_drop <= 1'b0;
        end else if (o_mem_req) begin
          r_drop    <= 1'b1;
          r_pc_pend <= w_redir_pc;
        end else begin
          r_pc <= w_redir_pc;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        if (w_misalign) r_misaligned <= 1'b1;
`endif
      end else begin
        if (w_ack) begin
          if (r_drop) begin
            r_pc   <= r_pc_pend;
            r_drop <= 1'b0;
          end else begin
            r_pc <= r_pc + 32'd4;
          end
        end
        if (!i_stall) begin
          if (r_skid_valid) begin
            r_out_data   <= r_skid_data;
            r_out_pc     <= r_skid_pc;
            r_out_valid  <= 1'b1;
            r_skid_valid <= w_keep;
            if (w_keep) begin
              r_skid_data <= i_mem_rdata;
              r_skid_pc   <= r_pc;
            end
          end else if (w_keep) begin
            r_out_data  <= i_mem_rdata;
            r_out_pc    <= r_pc;
            r_out_valid <= 1'b1;
          end else begin
            r_out_valid <= 1'b0;
          end
        end else if (w_keep) begin
          if (!r_out_valid) begin
            r_out_data  <= i_mem_rdata;
            r_out_pc    <= r_pc;
            r_out_valid <= 1'b1;
          end else begin
            r_skid_data  <= i_mem_rdata;
            r_skid_pc    <= r_pc;
            r_skid_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected {instr, pc}, a monitor pops them.
// Directed checks cover reset, wait states, stall/skid, redirects, PC wrap and alignment.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_ack     (mem_ack),
    .i_mem_rdata   (mem_rdata),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_stall       (stall),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .o_instr_valid (instr_valid)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .o_fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input logic [31:0] data, input logic [31:0] pc);
    exp_q.push_back({data, pc});
  endtask

  // Monitor: an instruction is taken when valid and decode accepts it (or a redirect retires it).
  always @(negedge clk) begin
    if (rst_n && instr_valid && (!stall || redirect)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL monitor_unexpected: got instr %h pc %h, expected none", instr, instr_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({instr, instr_pc} !== e) begin
          n_fail++;
          $display("FAIL monitor_instr: got %h@%h expected %h@%h", instr, instr_pc, e[63:32], e[31:0]);
        end else begin
          $display("ok   monitor_instr: %h@%h", instr, instr_pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] THRU_DATA [3] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;

    // Reset values
    repeat (3) tick();
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h100);
    chk("rst_instr", instr, 32'h13);
    chk("rst_instr_pc", instr_pc, 32'h100);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_misaligned", {31'h0, fetch_misaligned}, 32'h0);
`endif

    // Back-to-back fetch with ack tied high
    rst_n = 1'b1;
    chk("pre_edge_mem_req", {31'h0, mem_req}, 32'h0);
    tick();
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("thru_req", {31'h0, mem_req}, 32'h1);
      chk("thru_addr", mem_addr, 32'h100 + 32'(4 * i));
      mem_rdata = THRU_DATA[i];
      expect_instr(THRU_DATA[i], 32'h100 + 32'(4 * i));
      tick();
      chk("thru_valid", {31'h0, instr_valid}, 32'h1);
    end
    mem_ack = 1'b0;
    tick();
    chk("thru_drain_valid", {31'h0, instr_valid}, 32'h0);

    // Reset mid-request, late acks ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'h0, mem_req}, 32'h0);
    repeat (2) tick();
    chk("rst_ack_ignored_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_ack_ignored_addr", mem_addr, 32'h100);
    mem_ack = 1'b0;
    rst_n = 1'b1;
    tick();

    // Wait states
    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", mem_addr, 32'h100);
      chk("wait_req", {31'h0, mem_req}, 32'h1);
      if (i == 2) begin
        mem_ack = 1'b1; mem_rdata = 32'h0020_0113;
        expect_instr(32'h0020_0113, 32'h100);
      end
      tick();
    end
    mem_ack = 1'b0;
    chk("wait_instr", instr, 32'h0020_0113);
    chk("wait_next_addr", mem_addr, 32'h104);

    // Stall with output valid: returning word goes to skid
    stall = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h00A0_0093;
    expect_instr(32'h00A0_0093, 32'h104);
    tick();
    mem_ack = 1'b0;
    chk("skid_req_low", {31'h0, mem_req}, 32'h0);
    chk("stall_hold_pc", instr_pc, 32'h100);
    tick();
    chk("stall_hold_instr", instr, 32'h0020_0113);
    stall = 1'b0;
    tick();
    chk("skid_out_instr", instr, 32'h00A0_0093);
    chk("skid_req_resume", {31'h0, mem_req}, 32'h1);
    chk("skid_next_addr", mem_addr, 32'h108);

    // Redirect during pending request
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("redir_valid", {31'h0, instr_valid}, 32'h0);
    chk("redir_addr_stable", mem_addr, 32'h108);
    tick();
    chk("redir_addr_stable2", mem_addr, 32'h108);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("drop_valid", {31'h0, instr_valid}, 32'h0);
    chk("drop_instr_nop", instr, 32'h13);
    chk("redir_new_addr", mem_addr, 32'h200);
    mem_rdata = 32'h0030_0193;
    expect_instr(32'h0030_0193, 32'h200);
    tick();
    mem_ack = 1'b0;
    chk("redir_instr_pc", instr_pc, 32'h200);

    // Redirect, ack and stall together
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    mem_ack = 1'b1; mem_rdata = 32'hBADC_0DE0;
    tick();
    stall = 1'b0; redirect = 1'b0;
    chk("coinc_valid", {31'h0, instr_valid}, 32'h0);
    chk("coinc_instr_nop", instr, 32'h13);
    chk("coinc_addr", mem_addr, 32'h200);
    mem_rdata = 32'h0040_0213;
    expect_instr(32'h0040_0213, 32'h200);
    tick();
    chk("coinc_next_addr", mem_addr, 32'h204);

    // PC wraps at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; mem_rdata = 32'h1111_1111;
    tick();
    redirect = 1'b0;
    chk("wrap_addr_top", mem_addr, 32'hFFFF_FFFC);
    mem_rdata = 32'h0060_0313;
    expect_instr(32'h0060_0313, 32'hFFFF_FFFC);
    tick();
    mem_ack = 1'b0;
    chk("wrap_addr_zero", mem_addr, 32'h0);

    // Misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h202;
    tick();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("misalign_flag", {31'h0, fetch_misaligned}, 32'h1);
    chk("misalign_req", {31'h0, mem_req}, 32'h0);
    chk("misalign_valid", {31'h0, instr_valid}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    repeat (2) tick();
    mem_ack = 1'b0;
    chk("misalign_req_held", {31'h0, mem_req}, 32'h0);
    chk("misalign_sticky", {31'h0, fetch_misaligned}, 32'h1);
`else
    chk("align_addr_stable", mem_addr, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    chk("align_forced_addr", mem_addr, 32'h200);
    mem_rdata = 32'h0050_0293;
    expect_instr(32'h0050_0293, 32'h200);
    tick();
    mem_ack = 1'b0;
    chk("align_instr_pc", instr_pc, 32'h200);
`endif

    repeat (2) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit that drives the decode stage's `instr` input. It holds the program counter and issues word requests to instruction memory over a req/ack handshake. It presents one instruction at a time with its PC, and redirects on taken branches and jumps signalled by execute. A one-entry skid buffer absorbs a returning fetch while decode stalls. Invalid slots are filled with a NOP so decode, which has no valid input, stays harmless.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk` in 1, rising-edge clock
- `reset` in 1, asynchronous, active-low
- `mem_req` out 1, fetch request
- `mem_addr` out 32, word address of the request
- `mem_ack` in 1, request accepted; `mem_rdata` valid this cycle
- `mem_rdata` in 32, instruction word
- `redirect` in 1, taken branch/jump from execute
- `redirect_pc` in 32, new PC
- `stall` in 1, decode cannot accept a new instruction
- `instr` out 32, instruction to decode; NOP 32'h0000_0013 when not valid
- `instr_pc` out 32, PC of `instr`
- `instr_valid` out 1, `instr` holds a fetched instruction
- `fetch_misaligned` out 1, only when `FETCH_ALIGN_CHECK_EN` is defined (see Configuration)

## Operation
- **State:** `pc`, output register, skid register (data, pc, valid), `drop` flag.
- **Request rules:**
  - `mem_req` = not in reset AND skid not full.
  - `mem_addr` = `pc`.
  - Once `mem_req` is high, `mem_addr` stays stable until the `mem_ack` cycle.
  - `mem_req` is not dropped mid-request except by reset.
- **Ack without drop:**
  - `pc <= pc + 4`, with 32-bit wrap (32'hFFFF_FFFC → 0).
  - If the output is empty or `stall` is low, the word goes to the output register.
  - Otherwise (`stall` high and output valid), the word goes to the skid.
- **Stall low with skid full:** skid moves to the output and the skid empties. A new ack in the same cycle refills the skid.
- **Stall high:** `instr`, `instr_pc` and `instr_valid` hold.
- **Redirect** (has priority over stall and ack):
  - Output and skid invalidate; `instr` becomes NOP next cycle.
  - `pc <= redirect_pc`.
  - If a request is pending with no ack this cycle, `drop` sets. The request continues until ack, its data is discarded, and `drop` clears. The next request uses `redirect_pc`.
  - If redirect and ack coincide, the data is discarded and the next cycle requests `redirect_pc`.
  - A second redirect while `drop` is set only updates `pc`.

## Timing
- **Reset values:**
  - `mem_req` 0, `mem_addr` `RESET_PC`.
  - `instr` 32'h0000_0013, `instr_pc` `RESET_PC`, `instr_valid` 0.
  - Skid empty, `drop` 0, `fetch_misaligned` 0.
- **After reset release:** `mem_req` is high on the first clock edge with `mem_addr` = `RESET_PC`.
- **Latency:** ack in cycle N → `instr_valid` in N+1.
- **Throughput:** with a same-cycle ack and no stall, one instruction per cycle.
- **Skid full:** at most one ack is absorbed into the skid during a stall. `mem_req` then falls in the following cycle until the skid drains.
- **Redirect latency:** redirect in cycle N → `instr_valid` 0 in N+1 → `mem_addr` = `redirect_pc` no later than the cycle after the pending ack.
- **Reset mid-request:** everything returns to reset values immediately. Any late `mem_ack` while `reset` is low is ignored.

## Configuration
- **`FETCH_ALIGN_CHECK_EN` defined:**
  - Port `fetch_misaligned` exists.
  - A redirect with `redirect_pc[1:0]` != 0 sets `fetch_misaligned` (sticky until reset), invalidates the outputs and holds `mem_req` low forever.
- **`FETCH_ALIGN_CHECK_EN` undefined:**
  - No port.
  - `redirect_pc[1:0]` is forced to 00.

## Test plan
- **Reset:** hold `reset` low 3 cycles → outputs at reset values. Release with `RESET_PC` = 0x100 and ack tied high → `mem_addr` 0x100, 0x104, 0x108 in consecutive cycles; `instr_valid` 1 from the second cycle.
- **Wait states:** ack after 2 wait cycles → `mem_addr` stable at 0x100 for 3 cycles; `instr` = `mem_rdata` one cycle after ack.
- **Stall:** assert `stall` with output valid, ack returns 0x00A00093 → skid holds it and `mem_req` falls. Drop `stall` → `instr` = 0x00A00093 next cycle and `mem_req` resumes.
- **Redirect during pending request:** redirect to 0x200 while the request to 0x108 waits → the 0x108 data is discarded, `instr` is NOP, the next `mem_addr` is 0x200, and `instr_pc` is 0x200 after its ack.
- **Redirect coinciding with ack and stall:** redirect, ack and `stall` in the same cycle → the ack data is discarded, `instr_valid` 0, and the next request is 0x200.
- **Alignment (`FETCH_ALIGN_CHECK_EN`):** redirect to 0x202 → `fetch_misaligned` 1 and `mem_req` 0 until reset. Without the macro → `mem_addr` 0x200.
